blit_param_seq: RTL and testbench



---
 rtl/blit_param_seq.sv | 180 ++++++++++++++++++
 tb/tb_blit_param_seq.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/blit_param_seq.sv
// blit_param_seq: outer-loop parameter-read sequencer for the blitter.
// On RDPAR it walks the enabled parameter words in index order. For each word it
// requests a bus cycle and emits one active-low load strobe. PARDN flags the final
// enabled word.
//
// Ports:
//   MasterClock  in   1       system clock, rising edge
//   SRESETL      in   1       asynchronous active-low reset
//   CCLK         in   1       clock enable; state/outputs advance only when high
//   RDPAR        in   1       start request, sampled in IDLE
//   PARMASK      in   NPARAM  per-word fetch enable, captured at start
//   CYCEND       in   1       bus cycle end, advances to the next word
//   ICYCEND      in   1       early cycle end, times the load strobe
//   PARABT       in   1       abort (only with BLIT_PARAM_ABORT_EN)
//   PARCRQ       out  1       look-ahead cycle request (combinational)
//   PARIDX       out  IDX_W   index of the word being fetched, 0 otherwise
//   LDL          out  NPARAM  active-low load strobes, registered
//   PARDN        out  1       parameters done, registered
//
// Configuration macro: BLIT_PARAM_ABORT_EN adds the PARABT abort input.

module blit_param_seq #(
    parameter int unsigned NPARAM = 3,
    parameter int unsigned IDX_W  = (NPARAM > 1) ? $clog2(NPARAM) : 1
) (
    input  logic              MasterClock,
    input  logic              SRESETL,
    input  logic              CCLK,
    input  logic              RDPAR,
    input  logic [NPARAM-1:0] PARMASK,
    input  logic              CYCEND,
    input  logic              ICYCEND,
`ifdef BLIT_PARAM_ABORT_EN
    input  logic              PARABT,
`endif
    output logic              PARCRQ,
    output logic [IDX_W-1:0]  PARIDX,
    output logic [NPARAM-1:0] LDL,
    output logic              PARDN
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [NPARAM-1:0] mask_q, mask_d;
    logic [NPARAM-1:0] ldl_q, ldl_d;
    logic              pardn_q, pardn_d;

    logic              abort_c;
    logic              first_vld_c;
    logic [IDX_W-1:0]  first_idx_c;
    logic              next_vld_c;
    logic [IDX_W-1:0]  next_idx_c;

`ifdef BLIT_PARAM_ABORT_EN
    assign abort_c = PARABT;
`else
    assign abort_c = 1'b0;
`endif

    // Lowest set bit of the incoming mask, and lowest captured bit above idx_q.
    // Scanning downward lets the last hit be the lowest index.
    always_comb begin
        first_vld_c = 1'b0;
        first_idx_c = '0;
        next_vld_c  = 1'b0;
        next_idx_c  = '0;
        for (int k = int'(NPARAM) - 1; k >= 0; k--) begin
            if (PARMASK[k]) begin
                first_vld_c = 1'b1;
                first_idx_c = IDX_W'(k);
            end
            if (mask_q[k] && (k > int'(idx_q))) begin
                next_vld_c = 1'b1;
                next_idx_c = IDX_W'(k);
            end
        end
    end

    // State register, including the registered outputs.
    always_ff @(posedge MasterClock or negedge SRESETL) begin
        if (!SRESETL) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            mask_q  <= '0;
            ldl_q   <= '1;
            pardn_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            mask_q  <= mask_d;
            ldl_q   <= ldl_d;
            pardn_q <= pardn_d;
        end
    end

    // Next state. The index returns to 0 whenever FETCH is left, so PARIDX needs no decode.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        mask_d  = mask_q;
        if (CCLK) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (RDPAR) begin
                        mask_d = PARMASK;
                        if (first_vld_c) begin
                            state_d = ST_FETCH;
                            idx_d   = first_idx_c;
                        end else begin
                            state_d = ST_DONE;
                            idx_d   = '0;
                        end
                    end
                end
                ST_FETCH: begin
                    if (abort_c) begin
                        state_d = ST_IDLE;
                        idx_d   = '0;
                    end else if (CYCEND) begin
                        if (next_vld_c) begin
                            idx_d = next_idx_c;
                        end else begin
                            state_d = ST_DONE;
                            idx_d   = '0;
                        end
                    end
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                    idx_d   = '0;
                end
                default: begin
                    state_d = ST_IDLE;
                    idx_d   = '0;
                end
            endcase
        end
    end

    // Outputs. Strobe and done values hold between CCLK ticks.
    always_comb begin
        ldl_d   = ldl_q;
        pardn_d = pardn_q;
        if (CCLK) begin
            ldl_d   = '1;
            pardn_d = 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    pardn_d = RDPAR && !first_vld_c;
                end
                ST_FETCH: begin
                    if (!abort_c && ICYCEND) begin
                        for (int k = 0; k < int'(NPARAM); k++) begin
                            if (IDX_W'(k) == idx_q) begin
                                ldl_d[k] = 1'b0;
                            end
                        end
                        pardn_d = !next_vld_c;
                    end
                end
                default: begin
                    pardn_d = 1'b0;
                end
            endcase
        end
    end

    // Look-ahead request is forced low while reset is asserted.
    assign PARCRQ = SRESETL && (state_d == ST_FETCH);
    assign PARIDX = idx_q;
    assign LDL    = ldl_q;
    assign PARDN  = pardn_q;

endmodule

// File: tb/tb_blit_param_seq.sv
// Self-checking bench for blit_param_seq with NPARAM=3. A queue-based reference
// model holds the remaining enabled word indices.
module tb_blit_param_seq;

    localparam int unsigned NP = 3;
    localparam int unsigned IW = 2;

    logic          clk;
    logic          rst_n;
    logic          cclk;
    logic          rdpar;
    logic [NP-1:0] parmask;
    logic          cycend;
    logic          icycend;
    logic          parabt;
    logic          parcrq;
    logic [IW-1:0] paridx;
    logic [NP-1:0] ldl;
    logic          pardn;

    int n_checks;
    int n_errors;

    // Reference model: phase 0 idle, 1 fetching, 2 done.
    int            m_phase;
    int            m_q[$];
    logic [NP-1:0] m_ldl;
    logic          m_pardn;

    blit_param_seq #(.NPARAM(NP)) dut (
        .MasterClock (clk),
        .SRESETL     (rst_n),
        .CCLK        (cclk),
        .RDPAR       (rdpar),
        .PARMASK     (parmask),
        .CYCEND      (cycend),
        .ICYCEND     (icycend),
`ifdef BLIT_PARAM_ABORT_EN
        .PARABT      (parabt),
`endif
        .PARCRQ      (parcrq),
        .PARIDX      (paridx),
        .LDL         (ldl),
        .PARDN       (pardn)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = 0;
        m_q.delete();
        m_ldl   = '1;
        m_pardn = 1'b0;
    endtask

    // One MasterClock cycle: drive inputs, check outputs, advance the model.
    task automatic step(input logic c, input logic r, input logic [NP-1:0] m,
                        input logic ce, input logic ice);
        int            nphase;
        int            start_q[$];
        logic [NP-1:0] n_ldl;
        logic          n_pardn;
        logic          do_pop;
        @(negedge clk);
        cclk = c; rdpar = r; parmask = m; cycend = ce; icycend = ice;
        #1;
        nphase  = m_phase;
        n_ldl   = m_ldl;
        n_pardn = m_pardn;
        do_pop  = 1'b0;
        if (c) begin
            n_ldl   = '1;
            n_pardn = 1'b0;
            if (m_phase == 0) begin
                if (r) begin
                    for (int i = 0; i < int'(NP); i++)
                        if (m[i]) start_q.push_back(i);
                    if (start_q.size() == 0) begin
                        nphase  = 2;
                        n_pardn = 1'b1;
                    end else begin
                        nphase = 1;
                    end
                end
            end else if (m_phase == 1) begin
                if (ice) begin
                    n_ldl[m_q[0]] = 1'b0;
                    n_pardn = (m_q.size() == 1);
                end
                if (ce) begin
                    do_pop = 1'b1;
                    nphase = (m_q.size() == 1) ? 2 : 1;
                end
            end else begin
                nphase = 0;
            end
        end
        check_eq("parcrq", 32'(parcrq), 32'(nphase == 1));
        check_eq("paridx", 32'(paridx), (m_phase == 1) ? 32'(m_q[0]) : 32'd0);
        check_eq("ldl",    32'(ldl),    32'(m_ldl));
        check_eq("pardn",  32'(pardn),  32'(m_pardn));
        if (c && m_phase == 0 && r) m_q = start_q;
        if (do_pop) void'(m_q.pop_front());
        m_phase = nphase;
        m_ldl   = n_ldl;
        m_pardn = n_pardn;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n = 1'b0; cclk = 1'b1; rdpar = 1'b1; parmask = '1;
        cycend = 1'b0; icycend = 1'b0; parabt = 1'b0;
        model_reset();

        // Reset state, with a start request present to confirm PARCRQ stays low.
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_ldl",    32'(ldl),    32'h7);
        check_eq("rst_pardn",  32'(pardn),  32'h0);
        check_eq("rst_parcrq", 32'(parcrq), 32'h0);
        check_eq("rst_paridx", 32'(paridx), 32'h0);
        @(negedge clk);
        rst_n = 1'b1; rdpar = 1'b0; parmask = '0;

        // All three words, cycle ends every second tick.
        step(1, 1, 3'b111, 0, 0);
        for (int w = 0; w < 3; w++) begin
            step(1, 0, 3'b000, 0, 0);
            step(1, 0, 3'b000, 1, 1);
        end
        repeat (3) step(1, 0, 3'b000, 0, 0);

        // Sparse mask: words 0 and 2 only.
        step(1, 1, 3'b101, 0, 0);
        for (int w = 0; w < 2; w++) begin
            step(1, 0, 3'b010, 0, 0);
            step(1, 0, 3'b010, 1, 1);
        end
        repeat (3) step(1, 0, 3'b000, 0, 0);

        // Zero mask: straight to done.
        step(1, 1, 3'b000, 0, 0);
        repeat (3) step(1, 0, 3'b000, 0, 0);

        // Single highest word, cycle end and strobe in separate ticks.
        step(1, 1, 3'b100, 0, 0);
        step(1, 0, 3'b000, 0, 1);
        step(1, 0, 3'b000, 1, 0);
        repeat (2) step(1, 0, 3'b000, 0, 0);

        // Clock enable every third cycle, start held high.
        for (int t = 0; t < 90; t++)
            step((t % 3) == 2, 1, NP'($urandom_range(0, 7)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

        // Random traffic.
        for (int t = 0; t < 1500; t++)
            step($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0,
                 NP'($urandom_range(0, 7)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

        // Asynchronous reset in the middle of word 1.
        repeat (3) step(1, 0, 3'b000, 0, 0);
        step(1, 1, 3'b111, 0, 0);
        step(1, 0, 3'b000, 1, 1);
        @(negedge clk);
        cclk = 1'b1; rdpar = 1'b1; cycend = 1'b0; icycend = 1'b1;
        #1;
        check_eq("mid_paridx", 32'(paridx), 32'h1);
        check_eq("mid_ldl",    32'(ldl),    32'h6);
        #1;
        rst_n = 1'b0;
        #1;
        check_eq("arst_ldl",    32'(ldl),    32'h7);
        check_eq("arst_pardn",  32'(pardn),  32'h0);
        check_eq("arst_parcrq", 32'(parcrq), 32'h0);
        check_eq("arst_paridx", 32'(paridx), 32'h0);
        @(negedge clk);
        rst_n = 1'b1; rdpar = 1'b0; icycend = 1'b0;
        model_reset();
        step(1, 1, 3'b111, 0, 0);
        step(1, 0, 3'b000, 0, 1);
        for (int t = 0; t < 200; t++)
            step($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
                 NP'($urandom_range(0, 7)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
